// File: rtl/cls_pkg.sv
// Shared ASCII constants, parser state encoding and argument helpers for the
// PMOD CLS SPI responder.
package cls_pkg;

  localparam logic [7:0] ASCII_ESC    = 8'h1B;
  localparam logic [7:0] ASCII_LBRACK = 8'h5B;
  localparam logic [7:0] ASCII_0      = 8'h30;
  localparam logic [7:0] ASCII_9      = 8'h39;
  localparam logic [7:0] ASCII_SEMI   = 8'h3B;
  localparam logic [7:0] ASCII_J      = 8'h6A;
  localparam logic [7:0] ASCII_H      = 8'h48;
  localparam logic [7:0] ASCII_SPACE  = 8'h20;
  localparam logic [7:0] ASCII_TILDE  = 8'h7E;

  typedef enum logic [1:0] {
    ST_TEXT,
    ST_ESC,
    ST_ARG0,
    ST_ARG1
  } t_cls_rsp_state;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  // Two decimal digits at most, so the result always fits in 7 bits.
  function automatic logic [6:0] arg_acc(input logic [6:0] a, input logic [7:0] b);
    return 7'(a * 7'd10) + 7'(b - ASCII_0);
  endfunction

endpackage

// File: rtl/spi_mode0_byte_rx.sv
// SPI mode 0 byte receiver: synchronizes SCK/CS_n/MOSI into the system clock
// domain and emits a one-cycle pulse for every completed byte.
module spi_mode0_byte_rx #(
  parameter int parm_sync_stages = 2
) (
  input  logic       i_ext_spi_clk_x,
  input  logic       i_srst,
  input  logic       i_sck,
  input  logic       i_cs_n,
  input  logic       i_mosi,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data
);

  logic [parm_sync_stages-1:0] sck_sync;
  logic [parm_sync_stages-1:0] cs_sync;
  logic [parm_sync_stages-1:0] mosi_sync;
  logic                        sck_s;
  logic                        cs_s;
  logic                        mosi_s;
  logic                        sck_prev;
  logic                        sck_rise;
  logic [2:0]                  bit_cnt;
  logic [6:0]                  shreg;

  assign sck_s    = sck_sync[parm_sync_stages-1];
  assign cs_s     = cs_sync[parm_sync_stages-1];
  assign mosi_s   = mosi_sync[parm_sync_stages-1];
  assign sck_rise = sck_s & ~sck_prev;

  always_ff @(posedge i_ext_spi_clk_x or posedge i_srst) begin
    if (i_srst) begin
      sck_sync     <= '0;
      cs_sync      <= '1;
      mosi_sync    <= '0;
      sck_prev     <= 1'b0;
      bit_cnt      <= 3'd0;
      shreg        <= 7'd0;
      o_byte_valid <= 1'b0;
      o_byte_data  <= 8'd0;
    end else begin
      sck_sync     <= {sck_sync[parm_sync_stages-2:0], i_sck};
      cs_sync      <= {cs_sync[parm_sync_stages-2:0], i_cs_n};
      mosi_sync    <= {mosi_sync[parm_sync_stages-2:0], i_mosi};
      sck_prev     <= sck_s;
      o_byte_valid <= 1'b0;
      if (sck_rise && !cs_s) begin
        shreg   <= {shreg[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          o_byte_valid <= 1'b1;
          o_byte_data  <= {shreg, mosi_s};
        end
      end else if (cs_s) begin
        // stale bits in shreg are shifted out by the next full byte
        bit_cnt <= 3'd0;
      end
    end
  end

endmodule

// File: rtl/pmod_cls_spi_responder.sv
// PMOD CLS display controller emulation: ESC-sequence parser, cursor and a
// 2x16 ASCII frame buffer fed by the SPI byte receiver.
//
// state   | meaning
// ST_TEXT | printable bytes written at cursor, ESC starts a sequence
// ST_ESC  | ESC seen, expecting '['
// ST_ARG0 | collecting first numeric argument (row / clear selector)
// ST_ARG1 | collecting second numeric argument after ';' (column)
module pmod_cls_spi_responder
  import cls_pkg::*;
#(
  parameter int parm_sync_stages = 2,
  parameter int parm_cols        = 16
) (
  input  logic         i_ext_spi_clk_x,
  input  logic         i_srst,
  input  logic         i_sck,
  input  logic         i_cs_n,
  input  logic         i_mosi,
  output logic         o_byte_valid,
  output logic [7:0]   o_byte_data,
  output logic         o_clear_pulse,
  output logic         o_err_pulse,
  output logic         o_cursor_row,
  output logic [4:0]   o_cursor_col,
  output logic [127:0] o_line1,
  output logic [127:0] o_line2
);

  localparam logic [4:0] COL_END = 5'(parm_cols);

  t_cls_rsp_state state, state_nxt;
  logic [6:0]     arg0, arg0_nxt;
  logic [6:0]     arg1, arg1_nxt;
  logic [1:0]     dig, dig_nxt;
  logic           wr_en, clr_en, cur_en, err_en;
  logic           cur_row_nxt;
  logic [4:0]     cur_col_nxt;
  logic [7:0]     fb [2][16];

  spi_mode0_byte_rx #(
    .parm_sync_stages(parm_sync_stages)
  ) u_rx (
    .i_ext_spi_clk_x(i_ext_spi_clk_x),
    .i_srst         (i_srst),
    .i_sck          (i_sck),
    .i_cs_n         (i_cs_n),
    .i_mosi         (i_mosi),
    .o_byte_valid   (o_byte_valid),
    .o_byte_data    (o_byte_data)
  );

  always_ff @(posedge i_ext_spi_clk_x or posedge i_srst) begin
    if (i_srst) begin
      state         <= ST_TEXT;
      arg0          <= 7'd0;
      arg1          <= 7'd0;
      dig           <= 2'd0;
      o_clear_pulse <= 1'b0;
      o_err_pulse   <= 1'b0;
      o_cursor_row  <= 1'b0;
      o_cursor_col  <= 5'd0;
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 16; c++)
          fb[r][c] <= ASCII_SPACE;
    end else begin
      state         <= state_nxt;
      arg0          <= arg0_nxt;
      arg1          <= arg1_nxt;
      dig           <= dig_nxt;
      o_clear_pulse <= clr_en;
      o_err_pulse   <= err_en;
      if (clr_en) begin
        o_cursor_row <= 1'b0;
        o_cursor_col <= 5'd0;
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 16; c++)
            fb[r][c] <= ASCII_SPACE;
      end else if (cur_en) begin
        o_cursor_row <= cur_row_nxt;
        o_cursor_col <= cur_col_nxt;
      end else if (wr_en && (o_cursor_col != COL_END)) begin
        fb[o_cursor_row][o_cursor_col[3:0]] <= o_byte_data;
        o_cursor_col <= o_cursor_col + 5'd1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    arg0_nxt    = arg0;
    arg1_nxt    = arg1;
    dig_nxt     = dig;
    wr_en       = 1'b0;
    clr_en      = 1'b0;
    cur_en      = 1'b0;
    err_en      = 1'b0;
    cur_row_nxt = arg0[0];
    cur_col_nxt = 5'd0;
    if (o_byte_valid) begin
      unique case (state)
        ST_TEXT: begin
          if (o_byte_data == ASCII_ESC)
            state_nxt = ST_ESC;
          else if (o_byte_data >= ASCII_SPACE && o_byte_data <= ASCII_TILDE)
            wr_en = 1'b1;
        end
        ST_ESC: begin
          if (o_byte_data == ASCII_LBRACK) begin
            state_nxt = ST_ARG0;
            arg0_nxt  = 7'd0;
            arg1_nxt  = 7'd0;
            dig_nxt   = 2'd0;
          end else begin
            err_en    = 1'b1;
            state_nxt = (o_byte_data == ASCII_ESC) ? ST_ESC : ST_TEXT;
          end
        end
        ST_ARG0, ST_ARG1: begin
          state_nxt = ST_TEXT;
          if (o_byte_data == ASCII_ESC) begin
            err_en    = 1'b1;
            state_nxt = ST_ESC;
          end else if (is_digit(o_byte_data)) begin
            if (dig == 2'd2) begin
              err_en = 1'b1;
            end else begin
              state_nxt = state;
              dig_nxt   = dig + 2'd1;
              if (state == ST_ARG0) arg0_nxt = arg_acc(arg0, o_byte_data);
              else                  arg1_nxt = arg_acc(arg1, o_byte_data);
            end
          end else if (state == ST_ARG0 && o_byte_data == ASCII_SEMI) begin
            state_nxt = ST_ARG1;
            dig_nxt   = 2'd0;
          end else if (state == ST_ARG0 && o_byte_data == ASCII_J) begin
            clr_en = 1'b1;
          end else if (o_byte_data == ASCII_H) begin
            // in ST_ARG0 arg1 is still 0, giving cursor(arg0,0)
            cur_col_nxt = arg1[4:0];
            if (arg0 <= 7'd1 && arg1 <= 7'd15) cur_en = 1'b1;
            else                               err_en = 1'b1;
          end else begin
            err_en = 1'b1;
          end
        end
        default: state_nxt = ST_TEXT;
      endcase
    end
  end

  always_comb begin
    o_line1 = '0;
    o_line2 = '0;
    for (int c = 0; c < 16; c++) begin
      o_line1[127-8*c -: 8] = fb[0][c];
      o_line2[127-8*c -: 8] = fb[1][c];
    end
  end

endmodule

// File: tb/tb_pmod_cls_spi_responder.sv
// Directed bench for the PMOD CLS SPI responder: drives SPI mode 0 bytes and
// checks frame buffer, cursor and pulse counts against hand-computed values.
module tb_pmod_cls_spi_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sck = 1'b0;
  logic         cs_n = 1'b1;
  logic         mosi = 1'b0;
  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         clear_pulse;
  logic         err_pulse;
  logic         cursor_row;
  logic [4:0]   cursor_col;
  logic [127:0] line1;
  logic [127:0] line2;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_clr = 0;
  int n_err = 0;
  int v0, c0, e0;
  logic [7:0] last_b = 8'h00;

  localparam logic [127:0] SPACES = {16{8'h20}};

  pmod_cls_spi_responder dut (
    .i_ext_spi_clk_x(clk),
    .i_srst         (rst),
    .i_sck          (sck),
    .i_cs_n         (cs_n),
    .i_mosi         (mosi),
    .o_byte_valid   (byte_valid),
    .o_byte_data    (byte_data),
    .o_clear_pulse  (clear_pulse),
    .o_err_pulse    (err_pulse),
    .o_cursor_row   (cursor_row),
    .o_cursor_col   (cursor_col),
    .o_line1        (line1),
    .o_line2        (line2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      if (byte_valid) begin
        n_valid++;
        last_b = byte_data;
      end
      if (clear_pulse) n_clr++;
      if (err_pulse)   n_err++;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b);
    mosi = b;
    wait_clk(4);
    sck = 1'b1;
    wait_clk(4);
    sck = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] b);
    cs_n = 1'b0;
    wait_clk(4);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(6);
  endtask

  task automatic send_text(input string s);
    for (int i = 0; i < s.len(); i++) xfer(s[i]);
  endtask

  task automatic snap();
    v0 = n_valid;
    c0 = n_clr;
    e0 = n_err;
  endtask

  initial begin
    wait_clk(5);
    rst = 1'b0;
    wait_clk(5);

    // 1: reset state
    check("rst_line1", line1, SPACES);
    check("rst_line2", line2, SPACES);
    check("rst_cursor", {cursor_row, cursor_col}, 6'd0);
    check("rst_pulses", {byte_valid, clear_pulse, err_pulse}, 3'b000);

    // 2: write "AB", then clear
    send_text("AB");
    check("ab_line1", line1, {"AB", {14{8'h20}}});
    check("ab_col", cursor_col, 5'd2);
    snap();
    xfer(8'h1B); xfer(8'h5B); xfer(8'h30); xfer(8'h6A);
    check("clr_count", n_clr - c0, 1);
    check("clr_line1", line1, SPACES);
    check("clr_cursor", {cursor_row, cursor_col}, 6'd0);
    check("clr_valid_count", n_valid - v0, 4);

    // 3: cursor to (1,0) and fill line 2
    snap();
    xfer(8'h1B); xfer(8'h5B); xfer(8'h31); xfer(8'h3B); xfer(8'h30); xfer(8'h30); xfer(8'h48);
    check("cur10", {cursor_row, cursor_col}, {1'b1, 5'd0});
    send_text("HELLO WORLD 1234");
    check("hello_line2", line2, "HELLO WORLD 1234");
    check("hello_cursor", {cursor_row, cursor_col}, {1'b1, 5'd16});
    check("hello_line1", line1, SPACES);
    check("hello_no_err", n_err - e0, 0);

    // 4: cursor (0,15), "XY" -> Y dropped
    xfer(8'h1B); xfer(8'h5B); xfer(8'h30); xfer(8'h3B); xfer(8'h31); xfer(8'h35); xfer(8'h48);
    check("cur015", {cursor_row, cursor_col}, {1'b0, 5'd15});
    send_text("XY");
    check("xy_line1", line1, {{15{8'h20}}, "X"});
    check("xy_col", cursor_col, 5'd16);
    check("xy_line2", line2, "HELLO WORLD 1234");

    // 5: out-of-range row, ESC + non-'[', three-digit argument
    snap();
    xfer(8'h1B); xfer(8'h5B); xfer(8'h35); xfer(8'h3B); xfer(8'h30); xfer(8'h30); xfer(8'h48);
    check("row5_err", n_err - e0, 1);
    check("row5_cursor", {cursor_row, cursor_col}, {1'b0, 5'd16});
    snap();
    xfer(8'h1B); xfer(8'h41);
    check("esc_a_err", n_err - e0, 1);
    check("esc_a_line1", line1, {{15{8'h20}}, "X"});
    snap();
    xfer(8'h1B); xfer(8'h5B); xfer(8'h31); xfer(8'h32); xfer(8'h33);
    check("dig3_err", n_err - e0, 1);
    check("dig3_cursor", {cursor_row, cursor_col}, {1'b0, 5'd16});

    // ESC inside a sequence restarts it with an error, then clear completes
    snap();
    xfer(8'h1B); xfer(8'h1B); xfer(8'h5B); xfer(8'h30); xfer(8'h6A);
    check("esc_restart_err", n_err - e0, 1);
    check("esc_restart_clr", n_clr - c0, 1);
    check("esc_restart_line2", line2, SPACES);
    check("esc_restart_cursor", {cursor_row, cursor_col}, 6'd0);

    // 6: partial byte discarded on CS_n rise
    snap();
    cs_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 5; i++) spi_bit(1'b1);
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
    check("partial_no_valid", n_valid - v0, 0);
    xfer(8'h41);
    check("after_partial_valid", n_valid - v0, 1);
    check("after_partial_byte", last_b, 8'h41);
    check("after_partial_line1", line1, {"A", {15{8'h20}}});
    check("after_partial_col", cursor_col, 5'd1);

    // reset mid-sequence
    xfer(8'h1B); xfer(8'h5B); xfer(8'h31);
    rst = 1'b1;
    wait_clk(3);
    check("midrst_line1", line1, SPACES);
    check("midrst_cursor", {cursor_row, cursor_col}, 6'd0);
    rst = 1'b0;
    wait_clk(4);
    xfer(8'h5A);
    check("z_line1", line1, {"Z", {15{8'h20}}});
    check("z_cursor", {cursor_row, cursor_col}, {1'b0, 5'd1});
    check("z_line2", line2, SPACES);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
